if_stage: RTL

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the fetch PC and drives a single-outstanding req/ack instruction bus.
- Buffers fetched {pc, inst} pairs in a small FIFO; presents them to decode with a valid/ready handshake.
- Takes PC redirects from later stages; drops stale buffered and in-flight instructions on redirect.

---
 rtl/if_stage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding ibus requests,
// buffers {pc, inst} in a small FIFO for decode. Optional macro IF_ADDR_EXC_EN flags misaligned PCs.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_exc_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

  function automatic logic [31:0] load_pc(input logic [31:0] pc);
`ifdef IF_ADDR_EXC_EN
    return pc;
`else
    return pc & 32'hFFFF_FFFC;
`endif
  endfunction

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   stale_pc_q, stale_pc_d;
`ifdef IF_ADDR_EXC_EN
  logic          halt_q, halt_d;
`endif

  logic [31:0]   mem_pc_q   [FIFO_DEPTH];
  logic [31:0]   mem_pc_d   [FIFO_DEPTH];
  logic [31:0]   mem_inst_q [FIFO_DEPTH];
  logic [31:0]   mem_inst_d [FIFO_DEPTH];
  logic          mem_exc_q  [FIFO_DEPTH];
  logic          mem_exc_d  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          ibus_req_q, ibus_req_d;
  logic [31:0]   ibus_addr_q, ibus_addr_d;
  logic          if_valid_q, if_valid_d;
  logic [31:0]   if_pc_q, if_pc_d;
  logic [31:0]   if_inst_q, if_inst_d;
  logic          if_exc_q, if_exc_d;

  logic          push, pop, flush, push_exc;
  logic [31:0]   push_inst;
  logic [CW-1:0] free_pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_pc_d = stale_pc_q;
`ifdef IF_ADDR_EXC_EN
    halt_d     = halt_q;
`endif
    push      = 1'b0;
    push_inst = ibus_rdata_i;
    push_exc  = 1'b0;
    flush     = 1'b0;
    pop       = if_valid_q & id_ready_i;
    // free slots once this cycle's pop is accounted for; push is subtracted below
    free_pop  = DEPTH_C - (count_q - CW'(pop));

    if (redirect_i) begin
      flush      = 1'b1;
      fetch_pc_d = load_pc(redirect_pc_i);
`ifdef IF_ADDR_EXC_EN
      halt_d     = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (!redirect_i && free_pop != '0) begin
`ifdef IF_ADDR_EXC_EN
          if (fetch_pc_q[1:0] != 2'b00) begin
            if (!halt_q) begin
              push      = 1'b1;
              push_inst = 32'h0;
              push_exc  = 1'b1;
              halt_d    = 1'b1;
            end
          end else
`endif
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_i) begin
          if (!ibus_ack_i) begin
            stale_pc_d = ibus_addr_q;
            state_d    = DISCARD;
          end
        end else if (ibus_ack_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (free_pop == CW'(1)) state_d = IDLE;
        end
      end
      DISCARD: begin
        if (ibus_ack_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

`ifdef IF_ADDR_EXC_EN
    // a misaligned target is never put on the bus; IDLE raises the exception entry
    if (state_d == REQ && fetch_pc_d[1:0] != 2'b00) state_d = IDLE;
`endif

    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    mem_exc_d  = mem_exc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]   = fetch_pc_q;
        mem_inst_d[wr_ptr_q] = push_inst;
        mem_exc_d[wr_ptr_q]  = push_exc;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    ibus_req_d = (state_d != IDLE);
    case (state_d)
      REQ:     ibus_addr_d = fetch_pc_d;
      DISCARD: ibus_addr_d = stale_pc_d;
      default: ibus_addr_d = 32'h0;
    endcase
    if_valid_d = (count_d != '0);
    if_pc_d    = if_valid_d ? mem_pc_d[rd_ptr_d]   : 32'h0;
    if_inst_d  = if_valid_d ? mem_inst_d[rd_ptr_d] : 32'h0;
    if_exc_d   = if_valid_d ? mem_exc_d[rd_ptr_d]  : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= load_pc(RESET_PC);
      stale_pc_q  <= 32'h0;
`ifdef IF_ADDR_EXC_EN
      halt_q      <= 1'b0;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_q[i]   <= 32'h0;
        mem_inst_q[i] <= 32'h0;
        mem_exc_q[i]  <= 1'b0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ibus_req_q  <= 1'b0;
      ibus_addr_q <= 32'h0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'h0;
      if_inst_q   <= 32'h0;
      if_exc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      stale_pc_q  <= stale_pc_d;
`ifdef IF_ADDR_EXC_EN
      halt_q      <= halt_d;
`endif
      mem_pc_q    <= mem_pc_d;
      mem_inst_q  <= mem_inst_d;
      mem_exc_q   <= mem_exc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ibus_req_q  <= ibus_req_d;
      ibus_addr_q <= ibus_addr_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_exc_q    <= if_exc_d;
    end
  end

  assign ibus_req_o  = ibus_req_q;
  assign ibus_addr_o = ibus_addr_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign if_exc_o    = if_exc_q;

endmodule
